// File: rtl/ram_model_pkg.sv
// ram_model_pkg
// Shared definitions for the main-memory model and the motherboard RAM stage:
// ram_ctrl / ram_stat bit positions and the handshake FSM state encoding.
package ram_model_pkg;

    // ram_ctrl bit indices
    localparam int RAM_READ_PIN  = 0;
    localparam int RAM_WRITE_PIN = 1;

    // ram_stat bit indices
    localparam int RAM_ACK  = 0;
    localparam int RAM_BUSY = 1;
    localparam int RAM_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } ram_state_t;

    function automatic logic is_request(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/ram_model_array.sv
// ram_model_array
// Plain word storage: synchronous write, registered read.
// The array contents are never reset; only the read register is.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (clears rdata only)
//   we     write enable, mem[addr] <= wdata
//   re     read enable, rdata <= mem[addr]; rdata holds otherwise
//   addr   word index
//   wdata  write data
//   rdata  registered read data
module ram_model_array #(
    parameter int word_width = 32,
    parameter int DEPTH      = 1024,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [AW-1:0]         addr,
    input  logic [word_width-1:0] wdata,
    output logic [word_width-1:0] rdata
);

    logic [word_width-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_model.sv
// ram_model
// Single-port word RAM with a four-phase request/ack handshake and a
// configurable access latency. Used as main memory in simulation.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for a read or write request
// WAIT    | counting down the access latency, BUSY high
// ACK     | access done, ACK held until both pins drop
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   ram_ctrl  request pins (RAM_READ_PIN, RAM_WRITE_PIN)
//   addr      word address, full width compared against DEPTH
//   data_out  write data from the master
//   ram_stat  status (RAM_ACK, RAM_BUSY, RAM_ERR), other bits 0
//   data_in   read data to the master
module ram_model
    import ram_model_pkg::*;
#(
    parameter int word_width = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] ram_ctrl,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_out,
    output logic [word_width-1:0] ram_stat,
    output logic [word_width-1:0] data_in
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ram_state_t            state;
    logic [7:0]            cnt;
    logic                  op_rd;
    logic                  op_wr;
    logic [word_width-1:0] addr_q;
    logic [word_width-1:0] wdata_q;
    logic                  stat_ack;
    logic                  stat_busy;
    logic                  stat_err;
    logic                  rd_zero;

    logic                  pin_rd;
    logic                  pin_wr;
    logic                  in_range;
    logic                  both_pins;
    logic                  commit;
    logic                  arr_we;
    logic                  arr_re;
    logic [word_width-1:0] arr_rdata;
    logic                  unused_ctrl;

    assign pin_rd      = ram_ctrl[RAM_READ_PIN];
    assign pin_wr      = ram_ctrl[RAM_WRITE_PIN];
    assign unused_ctrl = ^ram_ctrl;

    // Full-width compare so out-of-range addresses never alias into the array.
    assign in_range  = (addr_q < word_width'(DEPTH));
    assign both_pins = op_rd & op_wr;

    // Gated by rst so a reset landing on the commit edge aborts the write.
    assign commit = (state == ST_WAIT) && (cnt == 8'd0) && !rst;
    assign arr_we = commit && op_wr && !op_rd && in_range;
    assign arr_re = commit && op_rd && !op_wr && in_range;

    ram_model_array #(
        .word_width (word_width),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            op_rd     <= 1'b0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            stat_ack  <= 1'b0;
            stat_busy <= 1'b0;
            stat_err  <= 1'b0;
            rd_zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_request(pin_rd, pin_wr)) begin
                        op_rd     <= pin_rd;
                        op_wr     <= pin_wr;
                        addr_q    <= addr;
                        wdata_q   <= data_out;
                        cnt       <= 8'(LATENCY - 1);
                        stat_busy <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 8'd0) begin
                        stat_busy <= 1'b0;
                        stat_ack  <= 1'b1;
                        stat_err  <= both_pins | !in_range;
                        // Out-of-range reads present zero until the next good read.
                        if (op_rd && !op_wr) begin
                            rd_zero <= !in_range;
                        end
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ACK: begin
                    if (!pin_rd && !pin_wr) begin
                        stat_ack <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ram_stat           = '0;
        ram_stat[RAM_ACK]  = stat_ack;
        ram_stat[RAM_BUSY] = stat_busy;
        ram_stat[RAM_ERR]  = stat_err;
    end

    assign data_in = rd_zero ? '0 : arr_rdata;

endmodule

// File: tb/tb_ram_model.sv
module tb_ram_model;
    import ram_model_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         sel;
    logic [W-1:0] ctrl;
    logic [W-1:0] addr;
    logic [W-1:0] dout;

    logic [W-1:0] ctrl1, ctrl2;
    logic [W-1:0] stat1, stat2, din1, din2;
    logic [W-1:0] stat, din;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    assign ctrl2 = sel ? '0 : ctrl;
    assign ctrl1 = sel ? ctrl : '0;
    assign stat  = sel ? stat1 : stat2;
    assign din   = sel ? din1 : din2;

    ram_model #(.word_width(W), .DEPTH(DEPTH), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .ram_ctrl(ctrl2), .addr(addr),
        .data_out(dout), .ram_stat(stat2), .data_in(din2)
    );

    ram_model #(.word_width(W), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ram_ctrl(ctrl1), .addr(addr),
        .data_out(dout), .ram_stat(stat1), .data_in(din1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives a request, perturbs addr/data during WAIT,
    // waits for ack and compares against the scoreboard head.
    task automatic access(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] exp_d, input logic exp_e);
        int   n;
        int   lat_exp;
        exp_t e;
        lat_exp = sel ? 1 : 2;
        sb.push_back('{data: exp_d, err: exp_e});
        ctrl = {30'd0, op};
        addr = a;
        dout = d;
        @(posedge clk);
        @(negedge clk);
        addr = a + 32'd1;
        dout = ~d;
        n = 0;
        while (!stat[RAM_ACK] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, W'(n), W'(lat_exp));
        e = sb.pop_front();
        chk({tag, ".ack"},  W'(stat[RAM_ACK]),  W'(1));
        chk({tag, ".busy"}, W'(stat[RAM_BUSY]), W'(0));
        chk({tag, ".err"},  W'(stat[RAM_ERR]),  W'(e.err));
        chk({tag, ".data"}, din, e.data);
    endtask

    task automatic release_req(input string tag);
        ctrl = '0;
        @(negedge clk);
        chk({tag, ".ack_drop"}, W'(stat[RAM_ACK]), W'(0));
    endtask

    initial begin
        sel  = 1'b0;
        rst  = 1'b1;
        ctrl = '0;
        addr = '0;
        dout = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset.stat2", stat2, '0);
        chk("reset.din2",  din2,  '0);
        chk("reset.stat1", stat1, '0);
        chk("reset.din1",  din1,  '0);

        // Reset in the WAIT cycle aborts the write.
        access("w5_init", 2'b10, 32'd5, 32'h1111_1111, 32'h0, 1'b0);
        release_req("w5_init");
        ctrl = 32'd2;
        addr = 32'd5;
        dout = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        chk("abort.busy", W'(stat[RAM_BUSY]), W'(1));
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        ctrl = '0;
        chk("abort.stat", stat, '0);
        chk("abort.din",  din,  '0);
        access("r5_after_abort", 2'b01, 32'd5, 32'h0, 32'h1111_1111, 1'b0);
        release_req("r5_after_abort");

        // Basic write/read at LATENCY=2.
        access("w3", 2'b10, 32'd3, 32'h1234_5678, 32'h1111_1111, 1'b0);
        release_req("w3");
        access("r3", 2'b01, 32'd3, 32'h0, 32'h1234_5678, 1'b0);
        release_req("r3");

        // Out of range accesses and no aliasing onto word 7.
        access("w7", 2'b10, 32'd7, 32'h7777_0007, 32'h1234_5678, 1'b0);
        release_req("w7");
        access("r_oor", 2'b01, DEPTH, 32'h0, 32'h0, 1'b1);
        release_req("r_oor");
        access("w_oor", 2'b10, DEPTH + 7, 32'hBAD0_BAD0, 32'h0, 1'b1);
        release_req("w_oor");
        access("r7", 2'b01, 32'd7, 32'h0, 32'h7777_0007, 1'b0);
        release_req("r7");

        // Both pins high: fault, nothing accessed, data_in unchanged.
        access("both", 2'b11, 32'd3, 32'hFFFF_FFFF, 32'h7777_0007, 1'b1);
        release_req("both");
        access("r3_after_both", 2'b01, 32'd3, 32'h0, 32'h1234_5678, 1'b0);
        release_req("r3_after_both");

        // Held ack.
        access("held", 2'b01, 32'd5, 32'h0, 32'h1111_1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held.ack",  W'(stat[RAM_ACK]),  W'(1));
            chk("held.busy", W'(stat[RAM_BUSY]), W'(0));
        end
        release_req("held");

        // LATENCY=1 back-to-back.
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            access("l1_w", 2'b10, W'(i), 32'hA0 + W'(i), 32'h0, 1'b0);
            release_req("l1_w");
        end
        for (int i = 0; i < 4; i++) begin
            access("l1_r", 2'b01, W'(i), 32'h0, 32'hA0 + W'(i), 1'b0);
            release_req("l1_r");
        end

        chk("sb_empty", W'(sb.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
